offchip_link_rx: RTL
====================

# offchip_link_rx

- Receive end of the 2-lane off-chip link.
- Collects 2-bit link symbols (four per byte, bit-interleaved: symbol k carries {bit[4+k], bit[k]}) and reassembles bytes.
- Buffers bytes in a DEPTH-entry FIFO plus one output register, presents them on a valid/ready interface, and returns one credit pulse per consumed byte to the link transmitter.

## Interface
Parameters:
- DEPTH, 8: FIFO entries (power of 2, ≥2); transmitter's initial credit count equals DEPTH.
- LW, $clog2(DEPTH)+2: width of level output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- lnk_valid  in  1  symbol valid this cycle.
- lnk_sym  in  2  symbol {bit[4+k], bit[k]}.
- lnk_sof  in  1  marks symbol k=0 of a byte; qualified by lnk_valid.
- data_out  out  8  byte at head of output stage.
- valid_out  out  1  data_out valid.
- ready  in  1  consumer accepts data_out.
- credit_ret  out  1  one-cycle pulse per popped byte.
- err_align  out  1  sticky alignment error.
- err_ovf  out  1  sticky overflow error.
- level  out  LW  bytes held (FIFO + output register), 0..DEPTH+1.

## Operation
- Assembler FSM states: HUNT, SYM1, SYM2, SYM3.
  - HUNT:
    - lnk_valid & lnk_sof: capture symbol into bits [4],[0]; go to SYM1.
    - lnk_valid & !lnk_sof: drop the symbol; set err_align.
  - SYMk (k=1..3), lnk_valid & !lnk_sof: capture into bits [4+k],[k].
    - SYM1 → SYM2, SYM2 → SYM3.
    - SYM3 completes the byte and returns to HUNT.
  - SYMk, lnk_valid & lnk_sof: set err_align; discard the partial byte; capture the symbol as k=0; go to SYM1.
  - lnk_valid=0: hold state and partial byte, with no timeout.
- Byte completion writes the assembled byte into the FIFO at the same edge.
  - FIFO full (DEPTH entries) at completion: drop the byte, set err_ovf, leave FIFO unchanged.
- Output register loads from the FIFO head when empty or being popped the same cycle.
- Pop: valid_out & ready. data_out and valid_out hold stable while valid_out & !ready.
- credit_ret is registered: high for exactly one cycle, the cycle after each pop. Back-to-back pops give back-to-back pulses.
- Pointers are log2(DEPTH)+1 bits, wrapping naturally.
  - Full: pointers differ only in MSB.
  - Empty: pointers equal.
- level counts FIFO entries plus output register occupancy. A same-edge write and pop leaves the count consistent.
- The FIFO accepts a write while full only if a same-cycle move into the output register frees an entry.
- Errors are sticky until reset and do not stall the datapath.

## Timing
- Reset (rst=0, asynchronous), all outputs 0:
  - FSM=HUNT, pointers 0, level=0.
  - data_out=0x00, valid_out=0, credit_ret=0, err_align=0, err_ovf=0.
- Release is synchronous: the first symbol is sampled at the first rising edge with rst=1.
- Latency with output stage empty:
  - Last symbol sampled at edge E.
  - FIFO write at E; output register loads at E+1; valid_out=1 after E+1.
  - With ready=1, pop at E+2; credit_ret=1 for the cycle after E+2.
- Sustained throughput is one byte per 4 symbol cycles. The output side sustains one pop per cycle.
- Reset asserted mid-byte or mid-transfer: partial byte and all buffered bytes are lost, and no credit_ret is issued. The transmitter re-initialises credits on the same reset.

## Configuration
- OFFCHIP_RX_ALIGN_CHECK_EN defined: lnk_sof is used for alignment and resynchronisation as described, and err_align is live.
- Undefined:
  - lnk_sof is ignored.
  - FSM starts at symbol k=0 out of reset and advances on every lnk_valid (HUNT acts as SYM0).
  - err_align is tied 0.

## Test plan
- Reset: drive rst=0 mid-stream → all outputs 0 within the same cycle, level=0; after release, first symbol is treated as a new byte.
- Single byte 0xA5: symbols 01(sof),10,01,10 on consecutive cycles, ready=1 → valid_out rises after E+1 with data_out=0xA5; one credit_ret pulse after E+2.
- Backpressure/fill, ready=0:
  - Send bytes 0x00..0x08 → level=9, err_ovf=0, data_out=0x00 held.
  - 10th byte 0x09 → err_ovf=1, dropped.
  - ready=1 → 0x00..0x08 in order, 9 consecutive credit_ret pulses, level returns 0.
- Misalignment (align macro on): sof, sym, sof, then 3 syms encoding 0x3C → err_align=1, single byte 0x3C output. Non-sof symbol in HUNT → dropped, err_align=1.
- Full + simultaneous:
  - FIFO full, ready=1 on the same cycle a byte completes → byte accepted, err_ovf=0, level unchanged.
  - Wrap: stream 20 bytes with ready toggling → output order preserved across pointer wrap.
- Macro off: lnk_sof held 0, 4 symbols 11,11,11,11 → data_out=0xFF, err_align stays 0.

Source files
------------

// File: rtl/offchip_link_rx.sv
// offchip_link_rx: receive end of the 2-lane off-chip link.
// Reassembles bit-interleaved 2-bit symbols into bytes, buffers them in a
// DEPTH-entry FIFO plus one output register, and returns one credit pulse
// per consumed byte.
//
// Build option: OFFCHIP_RX_ALIGN_CHECK_EN
//   defined   - lnk_sof aligns/resynchronises the assembler, err_align live.
//   undefined - lnk_sof ignored, every lnk_valid advances k, err_align = 0.
//
// Assembler states:
//   state | meaning
//   HUNT  | waiting for symbol k=0 (acts as SYM0 when alignment is off)
//   SYM1  | k=0 captured, waiting for k=1
//   SYM2  | k=0..1 captured, waiting for k=2
//   SYM3  | k=0..2 captured, next symbol completes the byte
module offchip_link_rx #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lnk_valid,
  input  logic [1:0]    lnk_sym,
  input  logic          lnk_sof,
  output logic [7:0]    data_out,
  output logic          valid_out,
  input  logic          ready,
  output logic          credit_ret,
  output logic          err_align,
  output logic          err_ovf,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {HUNT, SYM1, SYM2, SYM3} state_e;

  state_e      state_q, state_d;
  logic [7:0]  asm_q, asm_d;
  logic        byte_done;
  logic [7:0]  byte_val;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        wr_en;
  logic        ovf_set;

  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        pop;
  logic        load;
  logic        credit_q;
  logic        err_ovf_q;

`ifdef OFFCHIP_RX_ALIGN_CHECK_EN
  logic        align_err_set;
  logic        err_align_q;
`else
  logic        unused_sof;
  assign unused_sof = lnk_sof;
`endif

  // Assembler next-state: capture symbol k into bits {4+k, k}
  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    byte_done = 1'b0;
    byte_val  = asm_q;
`ifdef OFFCHIP_RX_ALIGN_CHECK_EN
    align_err_set = 1'b0;
    if (lnk_valid) begin
      if (lnk_sof) begin
        // A sof anywhere but HUNT means the previous byte was cut short.
        if (state_q != HUNT) align_err_set = 1'b1;
        asm_d   = {3'b000, lnk_sym[1], 3'b000, lnk_sym[0]};
        state_d = SYM1;
      end else begin
        case (state_q)
          HUNT: align_err_set = 1'b1;
          SYM1: begin
            asm_d[5] = lnk_sym[1];
            asm_d[1] = lnk_sym[0];
            state_d  = SYM2;
          end
          SYM2: begin
            asm_d[6] = lnk_sym[1];
            asm_d[2] = lnk_sym[0];
            state_d  = SYM3;
          end
          SYM3: begin
            byte_val  = {lnk_sym[1], asm_q[6:4], lnk_sym[0], asm_q[2:0]};
            byte_done = 1'b1;
            state_d   = HUNT;
          end
          default: state_d = HUNT;
        endcase
      end
    end
`else
    if (lnk_valid) begin
      case (state_q)
        HUNT: begin
          asm_d   = {3'b000, lnk_sym[1], 3'b000, lnk_sym[0]};
          state_d = SYM1;
        end
        SYM1: begin
          asm_d[5] = lnk_sym[1];
          asm_d[1] = lnk_sym[0];
          state_d  = SYM2;
        end
        SYM2: begin
          asm_d[6] = lnk_sym[1];
          asm_d[2] = lnk_sym[0];
          state_d  = SYM3;
        end
        SYM3: begin
          byte_val  = {lnk_sym[1], asm_q[6:4], lnk_sym[0], asm_q[2:0]};
          byte_done = 1'b1;
          state_d   = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
`endif
  end

  // Assembler state and partial byte registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      asm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
    end
  end

  assign fifo_cnt   = wptr_q - rptr_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign pop  = out_valid_q & ready;
  assign load = !fifo_empty & (!out_valid_q | pop);

  // A full FIFO still takes the byte when the head moves out this cycle;
  // the freed slot is the one being written, and its old value is read first.
  assign wr_en   = byte_done & (!fifo_full | load);
  assign ovf_set = byte_done & fifo_full & !load;

  // Pointer and output-stage next values
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (load) begin
      rptr_d      = rptr_q + 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rptr_q[AW-1:0]];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // FIFO storage; contents are meaningless until a pointer covers them
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= byte_val;
  end

  // Pointers, output register, credit pulse and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      credit_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      credit_q    <= pop;
      err_ovf_q   <= err_ovf_q | ovf_set;
    end
  end

`ifdef OFFCHIP_RX_ALIGN_CHECK_EN
  // Sticky alignment error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_align_q <= 1'b0;
    end else begin
      err_align_q <= err_align_q | align_err_set;
    end
  end
  assign err_align = err_align_q;
`else
  assign err_align = 1'b0;
`endif

  assign data_out   = out_data_q;
  assign valid_out  = out_valid_q;
  assign credit_ret = credit_q;
  assign err_ovf    = err_ovf_q;
  assign level      = LW'(fifo_cnt) + LW'(out_valid_q);

endmodule
